// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets NUM_REQ byte producers share one uart_tx.
// A granted byte is handed to the transmitter. The arbiter then waits for
// the transmitter to report activity and then completion. It inserts one
// gap cycle before the next grant. A transmitter that never reports
// activity is timed out and flagged on ack_err.
module uart_tx_arb #(
    parameter int NUM_REQ     = 4,
    parameter int PACK_SIZE   = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int GID_W       = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*PACK_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_byte_valid,
    output logic [PACK_SIZE-1:0]         tx_byte_data,
    input  logic                         tx_active,
    input  logic                         tx_done,
    output logic [GID_W-1:0]             grant_id,
    output logic                         busy,
    output logic                         ack_err
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

    state_t               state_q, state_d;
    logic                 tx_byte_valid_q, tx_byte_valid_d;
    logic [PACK_SIZE-1:0] tx_byte_data_q, tx_byte_data_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [GID_W-1:0]     grant_id_q, grant_id_d;
    logic [GID_W-1:0]     last_grant_q, last_grant_d;
    logic                 busy_q, busy_d;
    logic                 ack_err_q, ack_err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 rr_found;
    logic [GID_W-1:0]     rr_idx;
    logic [PACK_SIZE-1:0] req_bytes [NUM_REQ];

    // Split the flat request bus into one byte per requester
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_bytes[gi] = req_data[gi*PACK_SIZE +: PACK_SIZE];
        end
    endgenerate

    // Round-robin pick: the first pending requester after the last grant, wrapping around
    always_comb begin : p_rr
        int cand;
        cand     = 0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!rr_found && req_valid[cand[GID_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[GID_W-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output comes straight from a flop
    always_comb begin
        state_d         = state_q;
        tx_byte_valid_d = tx_byte_valid_q;
        tx_byte_data_d  = tx_byte_data_q;
        req_ready_d     = '0;
        grant_id_d      = grant_id_q;
        last_grant_d    = last_grant_q;
        ack_err_d       = 1'b0;
        cnt_d           = cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    tx_byte_data_d  = req_bytes[rr_idx];
                    tx_byte_valid_d = 1'b1;
                    req_ready_d     = NUM_REQ'(1) << rr_idx;
                    grant_id_d      = rr_idx;
                    last_grant_d    = rr_idx;
                    cnt_d           = '0;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                // tx_done is deliberately ignored here; only tx_active acknowledges the byte
                if (tx_active) begin
                    tx_byte_valid_d = 1'b0;
                    cnt_d           = '0;
                    state_d         = WAIT_DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    // Transmitter never responded: drop the byte but keep the rotation position
                    tx_byte_valid_d = 1'b0;
                    cnt_d           = '0;
                    ack_err_d       = 1'b1;
                    state_d         = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_done) state_d = GAP;
            end
            GAP: begin
                // Covers the transmitter's idle cycle in which tx_done may still be high
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset leaves requester 0 with first priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            tx_byte_valid_q <= 1'b0;
            tx_byte_data_q  <= '0;
            req_ready_q     <= '0;
            grant_id_q      <= '0;
            last_grant_q    <= GID_W'(NUM_REQ - 1);
            busy_q          <= 1'b0;
            ack_err_q       <= 1'b0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            tx_byte_valid_q <= tx_byte_valid_d;
            tx_byte_data_q  <= tx_byte_data_d;
            req_ready_q     <= req_ready_d;
            grant_id_q      <= grant_id_d;
            last_grant_q    <= last_grant_d;
            busy_q          <= busy_d;
            ack_err_q       <= ack_err_d;
            cnt_q           <= cnt_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign tx_byte_valid = tx_byte_valid_q;
    assign tx_byte_data  = tx_byte_data_q;
    assign grant_id      = grant_id_q;
    assign busy          = busy_q;
    assign ack_err       = ack_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb with a behavioural uart_tx stand-in (10 clocks per bit).
// Stimulus pushes expected grants and line bytes into queues. A separate monitor
// pops those entries and compares them whenever the arbiter grants or the
// transmitter accepts a byte.
module tb_uart_tx_arb;

    localparam int NR    = 4;
    localparam int PW    = 8;
    localparam int FRAME = 10 * 10;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*PW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            tx_byte_valid;
    logic [PW-1:0]   tx_byte_data;
    logic            tx_active;
    logic            tx_done;
    logic [1:0]      grant_id;
    logic            busy;
    logic            ack_err;

    uart_tx_arb #(.NUM_REQ(NR), .PACK_SIZE(PW), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_byte_valid(tx_byte_valid), .tx_byte_data(tx_byte_data),
        .tx_active(tx_active), .tx_done(tx_done), .grant_id(grant_id),
        .busy(busy), .ack_err(ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- uart_tx stand-in ----------------
    logic          uart_en;
    logic          acc_pulse;
    logic [PW-1:0] acc_byte;
    int            frame_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            acc_pulse <= 1'b0;
            acc_byte  <= '0;
            frame_cnt <= 0;
        end else begin
            acc_pulse <= 1'b0;
            tx_done   <= 1'b0;
            if (tx_active) begin
                if (frame_cnt == 0) begin
                    tx_active <= 1'b0;
                    tx_done   <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt - 1;
                end
            end else if (uart_en && tx_byte_valid && !tx_done) begin
                tx_active <= 1'b1;
                frame_cnt <= FRAME - 1;
                acc_pulse <= 1'b1;
                acc_byte  <= tx_byte_data;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]    id;
        logic [PW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [PW-1:0] line_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            ack_seen = 0;
    int            exp_ack  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_grant(input logic [1:0] id, input logic [PW-1:0] data, input bit sent);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
        if (sent) line_q.push_back(data);
    endtask

    // Monitor: compare every grant and every byte taken by the transmitter
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (req_ready != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_req_ready", 32'(req_ready), 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        $display("grant id=%0d data=%02h ready=%b", grant_id, tx_byte_data, req_ready);
                        check("req_ready", 32'(req_ready), 32'(1) << e.id);
                        check("grant_id", 32'(grant_id), 32'(e.id));
                        check("tx_byte_data", 32'(tx_byte_data), 32'(e.data));
                        check("tx_byte_valid_at_grant", 32'(tx_byte_valid), 32'd1);
                    end
                end
                if (acc_pulse) begin
                    if (line_q.size() == 0) begin
                        check("unexpected_line_byte", 32'(acc_byte), 32'hFFFF);
                    end else begin
                        logic [PW-1:0] d;
                        d = line_q.pop_front();
                        $display("line byte %02h", acc_byte);
                        check("line_byte", 32'(acc_byte), 32'(d));
                    end
                end
                if (ack_err) ack_seen++;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [NR-1:0] reload_v;
    logic [PW-1:0] reload_d [NR];

    // Advance one cycle; a requester drops its request (or loads its next byte) once accepted
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                if (reload_v[i]) begin
                    req_data[i*PW +: PW] = reload_d[i];
                    reload_v[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic raise(input int id, input logic [PW-1:0] data);
        req_data[id*PW +: PW] = data;
        req_valid[id] = 1'b1;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((busy || req_valid != '0 || tx_active) && n < 3000) begin
            step();
            n++;
        end
        check(name, 32'(busy), 32'd0);
        step();
        step();
    endtask

    initial begin
        int n;
        int hi;
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        uart_en   = 1'b1;
        reload_v  = '0;
        for (int i = 0; i < NR; i++) reload_d[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_byte_valid", 32'(tx_byte_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        rst = 1'b1;
        step();

        // All four pending: rotation 0,1,2,3 then requester 0 again with a second byte
        expect_grant(0, 8'h11, 1);
        expect_grant(1, 8'h22, 1);
        expect_grant(2, 8'h33, 1);
        expect_grant(3, 8'h44, 1);
        expect_grant(0, 8'h55, 1);
        reload_v[0] = 1'b1;
        reload_d[0] = 8'h55;
        raise(0, 8'h11);
        raise(1, 8'h22);
        raise(2, 8'h33);
        raise(3, 8'h44);
        wait_quiet("all_four_done");

        // Single requester 2 with A5; busy must fall two cycles after tx_done
        expect_grant(2, 8'hA5, 1);
        raise(2, 8'hA5);
        n = 0;
        while (!tx_done && n < 300) begin step(); n++; end
        check("wait_tx_done", 32'(tx_done), 32'd1);
        step();
        check("busy_1_after_done", 32'(busy), 32'd1);
        step();
        check("busy_2_after_done", 32'(busy), 32'd0);
        wait_quiet("single_done");

        // Grant to 3, then 0 and 3 together: wraps to 0 first
        expect_grant(3, 8'hD3, 1);
        raise(3, 8'hD3);
        wait_quiet("grant3_done");
        expect_grant(0, 8'hC0, 1);
        expect_grant(3, 8'hC3, 1);
        raise(0, 8'hC0);
        raise(3, 8'hC3);
        wait_quiet("wrap_done");

        // Transmitter never answers: valid held 16 cycles, one ack_err, byte dropped
        uart_en = 1'b0;
        expect_grant(1, 8'hE1, 0);
        exp_ack++;
        raise(1, 8'hE1);
        n = 0;
        while (!tx_byte_valid && n < 10) begin step(); n++; end
        hi = 0;
        while (tx_byte_valid && hi < 40) begin step(); hi++; end
        check("timeout_valid_cycles", 32'(hi), 32'd16);
        check("ack_err_pulse", 32'(ack_err), 32'd1);
        step();
        check("ack_err_width", 32'(ack_err), 32'd0);
        check("busy_after_timeout", 32'(busy), 32'd0);
        uart_en = 1'b1;
        // Rotation continues after the timed-out requester 1
        expect_grant(3, 8'hB3, 1);
        expect_grant(0, 8'hB0, 1);
        expect_grant(1, 8'hB1, 1);
        raise(0, 8'hB0);
        raise(1, 8'hB1);
        raise(3, 8'hB3);
        wait_quiet("after_timeout_done");

        // Requester 2 withdraws while requester 1 is transmitting: never granted
        expect_grant(1, 8'h77, 1);
        raise(1, 8'h77);
        n = 0;
        while (!tx_active && n < 20) begin step(); n++; end
        check("wait_active_withdraw", 32'(tx_active), 32'd1);
        raise(2, 8'h99);
        repeat (5) step();
        req_valid[2] = 1'b0;
        wait_quiet("withdraw_done");

        // Reset in the middle of a frame: outputs clear at once, then operation resumes
        expect_grant(3, 8'h5A, 1);
        raise(3, 8'h5A);
        n = 0;
        while (!tx_active && n < 20) begin step(); n++; end
        check("wait_active_reset", 32'(tx_active), 32'd1);
        repeat (30) step();
        #3;
        rst = 1'b0;
        #1;
        check("midrst_tx_byte_data", 32'(tx_byte_data), 32'd0);
        check("midrst_grant_id", 32'(grant_id), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_tx_byte_valid", 32'(tx_byte_valid), 32'd0);
        check("midrst_ack_err", 32'(ack_err), 32'd0);
        step();
        step();
        rst = 1'b1;
        expect_grant(1, 8'h3C, 1);
        raise(1, 8'h3C);
        wait_quiet("after_reset_done");

        repeat (3) step();
        check("grants_outstanding", 32'(exp_q.size()), 32'd0);
        check("line_bytes_outstanding", 32'(line_q.size()), 32'd0);
        check("ack_err_count", 32'(ack_seen), 32'(exp_ack));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop so the run cannot hang
    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
